// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
// The digit width and correction constants are also used by the downstream BCD adder.
package bin_to_bcd_seq_pkg;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_ADJ_THRESH = 5;
    localparam int BCD_ADJ_ADD    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and data bus between a controller and the converter.
interface bin_to_bcd_seq_if
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                          start;
    logic [BIN_W-1:0]              bin_in;
    logic                          busy;
    logic                          done;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out;
    logic                          overflow;

    modport master (output start, bin_in, input busy, done, bcd_out, overflow);
    modport slave  (input start, bin_in, output busy, done, bcd_out, overflow);

endinterface

// File: rtl/bin_to_bcd_seq_digit_adjust.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more before the shift.
module bcd_digit_adjust
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) ?
                     digit_i + BCD_DIGIT_W'(BCD_ADJ_ADD) : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_SHIFT | adjust + shift one bit per clock, BIN_W iterations
// ST_DONE  | one-cycle done pulse; start here is accepted back-to-back
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    bin_to_bcd_seq_if.slave  bus
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int SCR_W = BCD_W + BIN_W;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    state_e           state_q, state_d;
    logic [SCR_W-1:0] scr_q, scr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc_q, acc_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             ovf_q, ovf_d;

    logic [BCD_W-1:0] adj_bcd;
    logic [SCR_W-1:0] adj_scr;
    logic [SCR_W-1:0] shifted;
    logic             shift_out;
    logic             last_iter;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (scr_q[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (adj_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign adj_scr   = {adj_bcd, scr_q[BIN_W-1:0]};
    assign shifted   = {adj_scr[SCR_W-2:0], 1'b0};
    // A bit leaving the top digit means the value does not fit in DIGITS digits.
    assign shift_out = adj_scr[SCR_W-1];
    assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            scr_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_SHIFT;
                    scr_d   = {{BCD_W{1'b0}}, bus.bin_in};
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                scr_d = shifted;
                cnt_d = cnt_q + 1'b1;
                acc_d = acc_q | shift_out;
                if (last_iter) begin
                    state_d = ST_DONE;
                    bcd_d   = shifted[SCR_W-1:BIN_W];
                    ovf_d   = acc_q | shift_out;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy     = (state_q == ST_SHIFT);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: 8-bit/3-digit and 10-bit/3-digit instances.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) if8  ();
    bin_to_bcd_seq_if #(.BIN_W(10), .DIGITS(3)) if10 ();

    bin_to_bcd_seq #(.BIN_W(8),  .DIGITS(3)) dut8  (.clk(clk), .rst(rst), .bus(if8));
    bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) dut10 (.clk(clk), .rst(rst), .bus(if10));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits for done on the 8-bit instance, clearing start after the first edge.
    task automatic wait_done8(output bit got, output int bc, output int cyc);
        got = 1'b0; bc = 0; cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if8.start = 1'b0;
            cyc++;
            if (if8.busy) bc++;
            if (if8.done) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_done10(output bit got);
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if10.start = 1'b0;
            if (if10.done) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic conv8(input logic [7:0] v, output bit got, output int bc, output int cyc);
        @(negedge clk);
        if8.start  = 1'b1;
        if8.bin_in = v;
        wait_done8(got, bc, cyc);
    endtask

    function automatic logic [11:0] model_bcd(input int i);
        return {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
    endfunction

    initial begin
        bit got;
        int bc, cyc;
        logic [4:0] s;
        logic [3:0] sum;
        logic       cout;

        vecs[0] = '{8'd0,   12'h000};
        vecs[1] = '{8'd255, 12'h255};
        vecs[2] = '{8'd99,  12'h099};
        vecs[3] = '{8'd1,   12'h001};
        vecs[4] = '{8'd9,   12'h009};
        vecs[5] = '{8'd10,  12'h010};
        vecs[6] = '{8'd100, 12'h100};
        vecs[7] = '{8'd199, 12'h199};
        vecs[8] = '{8'd5,   12'h005};
        vecs[9] = '{8'd50,  12'h050};

        if8.start = 1'b0;  if8.bin_in = '0;
        if10.start = 1'b0; if10.bin_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_busy", 32'(if8.busy), 32'd0);
        check("rst_done", 32'(if8.done), 32'd0);
        check("rst_bcd",  32'(if8.bcd_out), 32'd0);
        check("rst_ovf",  32'(if8.overflow), 32'd0);

        // First conversion after reset: latency and busy width
        conv8(8'd0, got, bc, cyc);
        check("zero_done_seen", 32'(got), 32'd1);
        check("zero_busy_cycles", 32'(bc), 32'd8);
        check("zero_latency", 32'(cyc), 32'd9);
        check("zero_bcd", 32'(if8.bcd_out), 32'h000);
        @(negedge clk);
        check("done_one_cycle", 32'(if8.done), 32'd0);

        for (int i = 0; i < 10; i++) begin
            conv8(vecs[i].bin, got, bc, cyc);
            check($sformatf("vec%0d_done", i), 32'(got), 32'd1);
            check($sformatf("vec%0d_bcd", i), 32'(if8.bcd_out), 32'(vecs[i].bcd));
            check($sformatf("vec%0d_ovf", i), 32'(if8.overflow), 32'd0);
            if (vecs[i].bin == 8'd99) begin
                // Digits feed a single-digit BCD adder as A and B
                s = {1'b0, if8.bcd_out[3:0]} + {1'b0, if8.bcd_out[7:4]};
                cout = (s > 5'd9);
                sum  = cout ? 4'(s + 5'd6) : s[3:0];
                check("adder_sum", 32'(sum), 32'd8);
                check("adder_cout", 32'(cout), 32'd1);
            end
        end

        for (int i = 0; i < 256; i++) begin
            conv8(8'(i), got, bc, cyc);
            if (!got || if8.bcd_out !== model_bcd(i) || if8.overflow !== 1'b0)
                check($sformatf("exh_%0d", i), {19'd0, if8.overflow, if8.bcd_out}, {20'd0, model_bcd(i)});
            else
                checks++;
        end

        // start re-pulsed mid-SHIFT and bin_in changed while busy
        @(negedge clk);
        if8.start = 1'b1; if8.bin_in = 8'd200;
        repeat (3) begin
            @(negedge clk);
            if8.start = 1'b0;
        end
        if8.start = 1'b1; if8.bin_in = 8'd17;
        @(negedge clk);
        if8.start = 1'b0; if8.bin_in = 8'd77;
        wait_done8(got, bc, cyc);
        check("midstart_done", 32'(got), 32'd1);
        check("midstart_latency", 32'(cyc), 32'd5);
        check("midstart_bcd", 32'(if8.bcd_out), 32'h200);

        // start held in DONE: back-to-back with no IDLE cycle
        if8.start = 1'b1; if8.bin_in = 8'd42;
        wait_done8(got, bc, cyc);
        check("b2b_done", 32'(got), 32'd1);
        check("b2b_latency", 32'(cyc), 32'd9);
        check("b2b_busy_cycles", 32'(bc), 32'd8);
        check("b2b_bcd", 32'(if8.bcd_out), 32'h042);

        // reset mid-conversion aborts
        @(negedge clk);
        if8.start = 1'b1; if8.bin_in = 8'd123;
        repeat (4) begin
            @(negedge clk);
            if8.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(if8.busy), 32'd0);
        check("abort_done", 32'(if8.done), 32'd0);
        check("abort_bcd", 32'(if8.bcd_out), 32'd0);
        got = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (if8.done) got = 1'b1;
        end
        check("abort_no_done", 32'(got), 32'd0);
        conv8(8'd123, got, bc, cyc);
        check("after_abort_done", 32'(got), 32'd1);
        check("after_abort_bcd", 32'(if8.bcd_out), 32'h123);

        // 10-bit instance: overflow boundary
        @(negedge clk);
        if10.start = 1'b1; if10.bin_in = 10'd999;
        wait_done10(got);
        check("w10_999_done", 32'(got), 32'd1);
        check("w10_999_bcd", 32'(if10.bcd_out), 32'h999);
        check("w10_999_ovf", 32'(if10.overflow), 32'd0);
        @(negedge clk);
        if10.start = 1'b1; if10.bin_in = 10'd1000;
        wait_done10(got);
        check("w10_1000_done", 32'(got), 32'd1);
        check("w10_1000_ovf", 32'(if10.overflow), 32'd1);
        @(negedge clk);
        check("w10_ovf_held", 32'(if10.overflow), 32'd1);
        if10.start = 1'b1; if10.bin_in = 10'd512;
        wait_done10(got);
        check("w10_512_bcd", 32'(if10.bcd_out), 32'h512);
        check("w10_512_ovf", 32'(if10.overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
